stack_issue_ctrl: RTL
=====================

STACK_ISSUE_CTRL -- requirements
Module: stack_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning stack capacity in entries.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, meaning occupancy counter width.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports vld0_ID, vld1_ID  input  1  ID-stage slot valid.
REQ-006 SHALL have ports push0_ID, pop0_ID, push1_ID, pop1_ID  input  1  decoded stack ops per slot.
REQ-007 SHALL have port stall_ext  input  1  pipeline freeze from hazard unit.
REQ-008 SHALL have port flush  input  1  kill ID-stage instructions.
REQ-009 SHALL have port err_clr  input  1  clear sticky error flags.
REQ-010 SHALL have ports push0, pop0, push1, pop1  output  1  registered EX-stage strobes to the stack.
REQ-011 SHALL have port stall_ID  output  1  combinational request to hold ID one cycle.
REQ-012 SHALL have port depth  output  CW  shadow stack occupancy, 0..DEPTH.
REQ-013 SHALL have ports ovf, unf  output  1  sticky overflow / underflow flags.
REQ-014 SHALL have port illegal  output  1  one-cycle pulse: a slot requested push and pop together.

Function
REQ-015 Slot k is active only when vldk_ID=1; inactive slots issue nothing.
REQ-016 A slot with push and pop both set SHALL issue nothing and pulse illegal in the next cycle.
REQ-017 Slot 0 is evaluated before slot 1; slot 1 sees depth after slot 0's effect.
REQ-018 Push at depth==DEPTH SHALL be suppressed and set ovf; pop at depth==0 SHALL be suppressed and set unf.
REQ-019 FSM states: RUN, SPLIT; reset to RUN.
REQ-020 RUN->SPLIT when both slots are legal and same-direction with only one slot of room (push+push at DEPTH-1, pop+pop at 1): slot 0 issues, slot 1 is withheld, stall_ID=1.
REQ-021 SPLIT: slot 1 alone is re-evaluated against updated depth (normally suppressed with ovf/unf), stall_ID=0, SPLIT->RUN.
REQ-022 Mixed pairs (push0+pop1, pop0+push1) SHALL issue together with net depth change 0, subject to REQ-018 on slot 0.
REQ-023 Issue-to-strobe latency is exactly 1 cycle; strobes are high for exactly one cycle per issued op.
REQ-024 depth SHALL update in the issue cycle by +/-1 per issued op, saturating within 0..DEPTH, never wrapping.
REQ-025 stall_ext=1: no issue, strobes forced 0 next cycle, depth/state/flags hold.
REQ-026 flush=1: no issue, strobes 0 next cycle, state->RUN, depth holds; flush takes priority over stall_ext.
REQ-027 err_clr clears ovf/unf; a same-cycle new error wins (flag stays set).

Reset
REQ-028 rst SHALL force state RUN, depth 0, ovf 0, unf 0, illegal 0, all strobes 0 on the next posedge; stall_ID 0 while rst high.
REQ-029 Reset mid-SPLIT SHALL drop the withheld slot-1 op without issue.

Configuration
REQ-030 Macro STACK_ERR_TRAP_EN: when defined, any set ovf/unf/illegal blocks all further issue (stall_ID=1 while any slot requests a stack op) until err_clr; when undefined, errors only set flags and the offending op is dropped.

Structure
REQ-031 Package stack_pkg SHALL hold DEPTH default, the FSM state enum (RUN, SPLIT) and a slot-op typedef {push, pop, vld}.
REQ-032 Sub-module stack_slot_chk (per-slot legality/boundary check, instantiated twice) is the sole natural sub-module.

Verification
REQ-033 Reset, then push0 x3 singly -> push0 strobes 3 cycles, depth 3, no flags.
REQ-034 depth=1023, push0+push1 -> push0 strobe, stall_ID=1, next cycle push1 suppressed, ovf=1, depth 1024.
REQ-035 depth=0, pop0+push1 -> pop0 suppressed, unf=1, push1 strobe, depth 1.
REQ-036 Slot 0 push0_ID=pop0_ID=1 -> no strobes, illegal pulse 1 cycle, depth unchanged.
REQ-037 depth=5, pop0+pop1 with stall_ext=1 then 0 -> first cycle no strobes, second both pop strobes, depth 3.
REQ-038 rst asserted during SPLIT -> slot-1 op never strobed, depth 0, state RUN.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types for the stack issue controller: default capacity,
// controller FSM states and the per-slot decoded stack op.
package stack_pkg;

  localparam int STACK_DEPTH = 1024;

  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } state_t;

  typedef struct packed {
    logic push;
    logic pop;
    logic vld;
  } slot_op_t;

endpackage

// File: rtl/stack_slot_chk.sv
// Per-slot legality and boundary check. Takes the occupancy seen by this
// slot and returns what it may issue, any error it raises, and the
// occupancy the next slot should see.
module stack_slot_chk import stack_pkg::*; #(
  parameter int DEPTH = STACK_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  slot_op_t        op,
  input  logic            en,
  input  logic [CW-1:0]   depth_in,
  output logic            do_push,
  output logic            do_pop,
  output logic            ovf,
  output logic            unf,
  output logic            illegal,
  output logic [CW-1:0]   depth_out
);

  localparam logic [CW-1:0] DMAX = CW'(DEPTH);

  // push/pop together is illegal; boundary ops are suppressed and flagged
  always_comb begin
    do_push   = 1'b0;
    do_pop    = 1'b0;
    ovf       = 1'b0;
    unf       = 1'b0;
    illegal   = 1'b0;
    depth_out = depth_in;
    if (en && op.vld) begin
      if (op.push && op.pop) begin
        illegal = 1'b1;
      end else if (op.push) begin
        if (depth_in == DMAX) ovf = 1'b1;
        else begin
          do_push   = 1'b1;
          depth_out = depth_in + CW'(1);
        end
      end else if (op.pop) begin
        if (depth_in == '0) unf = 1'b1;
        else begin
          do_pop    = 1'b1;
          depth_out = depth_in - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stack_issue_ctrl.sv
// Dual-slot stack op issue controller. Tracks a shadow occupancy, issues
// registered EX strobes one cycle after ID, splits a same-direction pair
// across two cycles when only one entry of room remains.
// Optional: STACK_ERR_TRAP_EN -- any sticky error blocks further issue
// (and holds ID while stack ops are requested) until err_clr.
module stack_issue_ctrl import stack_pkg::*; #(
  parameter int DEPTH = STACK_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld0_ID,
  input  logic          vld1_ID,
  input  logic          push0_ID,
  input  logic          pop0_ID,
  input  logic          push1_ID,
  input  logic          pop1_ID,
  input  logic          stall_ext,
  input  logic          flush,
  input  logic          err_clr,
  output logic          push0,
  output logic          pop0,
  output logic          push1,
  output logic          pop1,
  output logic          stall_ID,
  output logic [CW-1:0] depth,
  output logic          ovf,
  output logic          unf,
  output logic          illegal
);

  localparam logic [CW-1:0] DM1 = CW'(DEPTH - 1);

  state_t              state;
  slot_op_t [1:0]      op;
  logic [1:0]          act, en, keep;
  logic [1:0]          s_push, s_pop, s_ovf, s_unf, s_ill;
  logic [2:0][CW-1:0]  dchain;
  logic [CW-1:0]       depth_nxt;
  logic                go, split, trap, flags_hold;

  assign op[0] = '{push: push0_ID, pop: pop0_ID, vld: vld0_ID};
  assign op[1] = '{push: push1_ID, pop: pop1_ID, vld: vld1_ID};

`ifdef STACK_ERR_TRAP_EN
  logic ill_seen;
  logic req_any;
  assign trap    = ovf | unf | ill_seen;
  assign req_any = (vld0_ID & (push0_ID | pop0_ID)) | (vld1_ID & (push1_ID | pop1_ID));
  assign stall_ID = ~rst & (split | (trap & req_any));

  // illegal is only a pulse, so remember it until software clears it
  always_ff @(posedge clk) begin
    if (rst) ill_seen <= 1'b0;
    else if (!flags_hold) ill_seen <= (ill_seen & ~err_clr) | (|(s_ill & keep));
  end
`else
  assign trap     = 1'b0;
  assign stall_ID = ~rst & split;
`endif

  // flush wins over stall_ext; neither lets anything issue
  assign go         = ~rst & ~flush & ~stall_ext & ~trap;
  assign flags_hold = stall_ext & ~flush;

  // in SPLIT slot 0 already went out; only slot 1 is re-evaluated
  assign en[0] = go & (state == RUN);
  assign en[1] = go;

  // slot 1 checks against depth after slot 0's effect
  assign dchain[0] = depth;

  for (genvar k = 0; k < 2; k++) begin : g_slot
    assign act[k] = op[k].vld & (op[k].push ^ op[k].pop);
    stack_slot_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
      .op        (op[k]),
      .en        (en[k]),
      .depth_in  (dchain[k]),
      .do_push   (s_push[k]),
      .do_pop    (s_pop[k]),
      .ovf       (s_ovf[k]),
      .unf       (s_unf[k]),
      .illegal   (s_ill[k]),
      .depth_out (dchain[k+1])
    );
  end

  // legal same-direction pair with one entry of room: hold slot 1 a cycle
  assign split = en[0] & act[0] & act[1] &
                 ((op[0].push & op[1].push & (depth == DM1)) |
                  (op[0].pop  & op[1].pop  & (depth == CW'(1))));
  assign keep      = {~split, 1'b1};
  assign depth_nxt = split ? dchain[1] : dchain[2];

  // FSM, occupancy, sticky flags and registered EX strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      depth   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      illegal <= 1'b0;
      push0   <= 1'b0;
      pop0    <= 1'b0;
      push1   <= 1'b0;
      pop1    <= 1'b0;
    end else begin
      push0   <= s_push[0];
      pop0    <= s_pop[0];
      push1   <= s_push[1] & keep[1];
      pop1    <= s_pop[1]  & keep[1];
      illegal <= |(s_ill & keep);
      depth   <= depth_nxt;
      if (flush)           state <= RUN;
      else if (!stall_ext) state <= split ? SPLIT : RUN;
      if (!flags_hold) begin
        ovf <= (ovf & ~err_clr) | (|(s_ovf & keep));
        unf <= (unf & ~err_clr) | (|(s_unf & keep));
      end
    end
  end

endmodule
